// File: rtl/arrmul_pkg.sv
// arrmul_pkg: shared ALU control encodings (element width, alu_op codes)
package arrmul_pkg;
  typedef enum logic [1:0] {w8 = 2'd0, w16 = 2'd1, w32 = 2'd2, w64 = 2'd3} ww_e;
  localparam logic [4:0] aluadd    = 5'h00;
  localparam logic [4:0] aluwmuleu = 5'h10;
  localparam logic [4:0] aluwmulou = 5'h11;
  localparam logic [4:0] aluwmules = 5'h12;
  localparam logic [4:0] aluwmulos = 5'h13;
  function automatic logic is_wmul(input logic [4:0] op);
    return op == aluwmuleu || op == aluwmulou || op == aluwmules || op == aluwmulos;
  endfunction
endpackage

// File: rtl/arrmul_mul16.sv
// mul16_lane: one 16x16 or two split 8x8 products from a carry-save partial-product array
module mul16_lane (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        sgn,
  input  logic        w16,
  output logic [31:0] p
);
  logic [31:0] a32, row, s, c, maj, kill, corr;
  logic [15:0] alo, ahi;
  logic        neg;
  // sign-extended rows; top row of each product subtracted when signed; carries killed at bit 16 in split mode
  always_comb begin
    alo = {{8{sgn & a[7]}}, a[7:0]};
    ahi = {{8{sgn & a[15]}}, a[15:8]};
    a32 = {{16{sgn & a[15]}}, a};
    kill = w16 ? 32'h0 : 32'h0001_0000;
    s = '0;
    c = '0;
    corr = '0;
    row = '0;
    maj = '0;
    neg = 1'b0;
    for (int j = 0; j < 16; j++) begin
      row = w16 ? (b[j] ? a32 << j : 32'h0) : j < 8 ? {16'h0, b[j] ? alo << j : 16'h0} : {b[j] ? ahi << (j - 8) : 16'h0, 16'h0};
      neg = sgn && (j == 15 || (!w16 && j == 7));
      row = neg ? ~row & (w16 ? 32'hffff_ffff : j < 8 ? 32'h0000_ffff : 32'hffff_0000) : row;
      corr = neg ? corr | ((!w16 && j == 15) ? 32'h0001_0000 : 32'h1) : corr;
      maj = (s & c) | (s & row) | (c & row);
      s = s ^ c ^ row;
      c = {maj[30:0], 1'b0} & ~kill;
    end
    maj = (s & c) | (s & corr) | (c & corr);
    s = s ^ c ^ corr;
    c = {maj[30:0], 1'b0} & ~kill;
    p = w16 ? s + c : {s[31:16] + c[31:16], s[15:0] + c[15:0]};
  end
endmodule

// File: rtl/arrmul.sv
// arrmul: registered SIMD even/odd element multiplier (8/16-bit, signed/unsigned)
module arrmul
  import arrmul_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic [0:127] reg_A,
  input  logic [0:127] reg_B,
  input  logic [0:1]   ctrl_ww,
  input  logic [0:4]   alu_op,
  output logic [0:127] result
);
  logic        odd, sgn, is16, valid;
  logic [31:0] prod [4];
  logic [0:127] nxt;
  assign odd = alu_op == aluwmulou || alu_op == aluwmulos;
  assign sgn = alu_op == aluwmules || alu_op == aluwmulos;
  assign is16 = ctrl_ww == w16;
  assign valid = is_wmul(alu_op) && (ctrl_ww == w8 || ctrl_ww == w16);
  for (genvar k = 0; k < 4; k++) begin : g_lane
    logic [31:0] xa, xb;
    logic [15:0] a, b;
    assign xa = reg_A[32*k +: 32];
    assign xb = reg_B[32*k +: 32];
    assign a = is16 ? (odd ? xa[15:0] : xa[31:16]) : (odd ? {xa[23:16], xa[7:0]} : {xa[31:24], xa[15:8]});
    assign b = is16 ? (odd ? xb[15:0] : xb[31:16]) : (odd ? {xb[23:16], xb[7:0]} : {xb[31:24], xb[15:8]});
    mul16_lane u_mul (.a(a), .b(b), .sgn(sgn), .w16(is16), .p(prod[k]));
  end
  assign nxt = valid ? {prod[0], prod[1], prod[2], prod[3]} : '0;
  // output register, cleared asynchronously while reset is low
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) result <= '0;
    else result <= nxt;
  end
endmodule

// File: tb/tb_arrmul.sv
// tb_arrmul: random and directed checks of arrmul against an arithmetic reference model
module tb_arrmul;
  import arrmul_pkg::*;
  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] A, B;
  logic [1:0]   ww;
  logic [4:0]   op;
  logic [127:0] result;
  logic [127:0] exp_q;
  logic         run = 1'b0;
  int           passed = 0, total = 0;

  arrmul dut (.clk(clk), .reset(reset), .reg_A(A), .reg_B(B), .ctrl_ww(ww), .alu_op(op), .result(result));

  always #5 clk = ~clk;

  function automatic logic [127:0] model(input logic [127:0] a, input logic [127:0] b, input logic [1:0] w, input logic [4:0] o);
    logic [127:0] r, m1, m2;
    int s, wd;
    bit sg;
    longint x, y, pr;
    r = '0;
    if (!(o == aluwmuleu || o == aluwmulou || o == aluwmules || o == aluwmulos) || !(w == w8 || w == w16)) return r;
    s = (o == aluwmulou || o == aluwmulos) ? 1 : 0;
    sg = (o == aluwmules || o == aluwmulos);
    wd = (w == w8) ? 8 : 16;
    m1 = (128'(1) << wd) - 1;
    m2 = (128'(1) << (2 * wd)) - 1;
    for (int k = 0; k < 128 / (2 * wd); k++) begin
      x = longint'((a >> (128 - (2 * k + s + 1) * wd)) & m1);
      y = longint'((b >> (128 - (2 * k + s + 1) * wd)) & m1);
      if (sg && x >= (64'sd1 << (wd - 1))) x = x - (64'sd1 << wd);
      if (sg && y >= (64'sd1 << (wd - 1))) y = y - (64'sd1 << wd);
      pr = x * y;
      r = r | ((128'(pr) & m2) << (128 - (k + 1) * 2 * wd));
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) $display("FAIL %s got=%h want=%h", nm, got, want);
    else passed++;
  endtask

  // reference output register: model of the inputs captured at each edge
  always @(posedge clk or negedge reset) begin
    if (!reset) exp_q <= '0;
    else exp_q <= model(A, B, ww, op);
  end

  // every-cycle comparison against the reference
  always @(negedge clk) if (run) chk("cycle", result, exp_q);

  task automatic lit(input string nm, input logic [127:0] a, input logic [127:0] b, input logic [1:0] w, input logic [4:0] o, input logic [127:0] want);
    @(negedge clk);
    A = a; B = b; ww = w; op = o;
    @(posedge clk);
    #1;
    chk(nm, result, want);
    chk({nm, "_model"}, model(a, b, w, o), want);
  endtask

  function automatic logic [127:0] rvec();
    logic [127:0] v;
    logic [7:0] sp [4];
    sp = '{8'h00, 8'h7f, 8'h80, 8'hff};
    for (int i = 0; i < 16; i++)
      v[8*i +: 8] = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 3)] : 8'($urandom);
    return v;
  endfunction

  initial begin
    logic [4:0] ops [4];
    ops = '{aluwmuleu, aluwmulou, aluwmules, aluwmulos};
    reset = 1'b0;
    A = '0; B = '0; ww = w8; op = aluadd;
    #1;
    chk("reset", result, '0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    run = 1'b1;
    lit("wmuleu_w8", 128'h0402030405060708f00a0b0cff0eff00, 128'h03010202030303031004f505ff09fe10, w8, aluwmuleu, 128'h000c0006000f00150f000a87fe01fd02);
    lit("wmulou_w8", 128'h0102030405060708090aff0c0dff0fff, 128'h01010202030303031004040508000fff, w8, aluwmulou, 128'h00020008001200180028003c0000fe01);
    lit("wmuleu_w16", 128'h000100020000ffff000f10bff103ffff, 128'h000200040006ffff000c100000120014, w16, aluwmuleu, 128'h0000000200000000000000b40010f236);
    lit("wmulos_w8", 128'h0180010501f9015301040100013c0100, 128'h017f010901fa010001fd01f101b80100, w8, aluwmulos, 128'hc080002d002a0000fff40000ef200000);
    lit("wmulos_w16", 128'h1111000211118000111120541111fff9, 128'hffff0004ffff7fffffff0000fffffffd, w16, aluwmulos, 128'h00000008c00080000000000000000015);
    lit("wmules_w16", 128'h000211118000111120541111fff91111, 128'h0004ffff7fffffff0000fffffffdffff, w16, aluwmules, 128'h00000008c00080000000000000000015);
    lit("w32_zero", 128'h0402030405060708f00a0b0cff0eff00, 128'h03010202030303031004f505ff09fe10, w32, aluwmuleu, '0);
    lit("w64_zero", 128'h0402030405060708f00a0b0cff0eff00, 128'h03010202030303031004f505ff09fe10, w64, aluwmulos, '0);
    lit("other_op", 128'h0402030405060708f00a0b0cff0eff00, 128'h03010202030303031004f505ff09fe10, w8, aluadd, '0);
    lit("pre_reset", 128'h0402030405060708f00a0b0cff0eff00, 128'h03010202030303031004f505ff09fe10, w8, aluwmuleu, 128'h000c0006000f00150f000a87fe01fd02);
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset", result, '0);
    @(negedge clk);
    reset = 1'b1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      A = rvec();
      B = rvec();
      ww = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      op = ($urandom_range(0, 9) == 0) ? 5'($urandom) : ops[$urandom_range(0, 3)];
    end
    repeat (2) @(negedge clk);
    run = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
